rc4_key_search_ctrl: RTL and testbench

Sequences a brute-force RC4 key search over a configurable key range. For each candidate key the block drives the secret key and a start pulse into the KSA/decrypt/checker datapath, waits for the checker's finish strobe, then advances to the next key or stops. It sits between the top-level cracking wrapper (buttons/LEDs/HEX) and one cracking core. Several instances can partition the key space through KEY_FIRST/KEY_STEP.

---
 rtl/rc4_crack_pkg.sv | 18 +
 rtl/rc4_watchdog.sv | 32 +++
 rtl/rc4_key_search_ctrl.sv | 126 ++++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_crack_pkg.sv
// Shared types for the RC4 key-search control slice: key width, key type and
// the search sequencer state encoding.
`timescale 1ns/1ps
package rc4_crack_pkg;
  localparam int KEY_WIDTH  = 24;
  localparam int WDOG_WIDTH = 32;

  typedef logic [KEY_WIDTH-1:0] key_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_FOUND,
    S_EXHAUSTED,
    S_FAULT
  } search_state_e;
endpackage

// File: rtl/rc4_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear and fires on the
// cycle the count reaches limit-1. A limit of zero disables firing.
`timescale 1ns/1ps
module rc4_watchdog
  import rc4_crack_pkg::*;
#(
  parameter int WIDTH = WDOG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic             fire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // fire is qualified by en so a cycle that is not counted can never trip it
  assign fire = en && (limit != '0) && (count == limit - 1'b1);

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// Brute-force RC4 key search sequencer: launches one candidate key at a time
// into the cracking core and stops on a match, range end or watchdog fault.
//
// state       | meaning
// S_IDLE      | waiting for start
// S_LAUNCH    | core_start pulse for core_key
// S_WAIT      | waiting for chk_finish, watchdog running
// S_FOUND     | match found, found_key holds it
// S_EXHAUSTED | range finished without a match
// S_FAULT     | watchdog expired waiting on the core
`timescale 1ns/1ps
module rc4_key_search_ctrl
  import rc4_crack_pkg::*;
#(
  parameter int                  KEY_WIDTH      = rc4_crack_pkg::KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] KEY_FIRST     = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST      = KEY_WIDTH'(24'h3FFFFF),
  parameter int                  KEY_STEP       = 1,
  parameter int                  TIMEOUT_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 core_start,
  output logic [KEY_WIDTH-1:0] core_key,
  input  logic                 chk_finish,
  input  logic                 chk_valid,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic                 timeout_err,
  output logic [KEY_WIDTH-1:0] found_key,
  output logic [KEY_WIDTH-1:0] keys_tried
);

  search_state_e state, state_nxt;

  logic [KEY_WIDTH-1:0] key_reg;
  logic [KEY_WIDTH:0]   key_sum;
  logic                 past_last;
  logic                 ld_first, inc_tried, set_found, adv_key;
  logic                 wd_clr, wd_en, wd_fire;

  // one extra bit so a step past the top of the key space cannot wrap to 0
  assign key_sum   = {1'b0, key_reg} + (KEY_WIDTH+1)'(KEY_STEP);
  assign past_last = key_sum > {1'b0, KEY_LAST};

  assign wd_clr = (state == S_LAUNCH);
  assign wd_en  = (state == S_WAIT) && !chk_finish;

  rc4_watchdog #(
    .WIDTH(WDOG_WIDTH)
  ) u_watchdog (
    .clk  (clk),
    .rst  (rst),
    .clr  (wd_clr),
    .en   (wd_en),
    .limit(WDOG_WIDTH'(TIMEOUT_CYCLES)),
    .fire (wd_fire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      key_reg    <= KEY_FIRST;
      found_key  <= '0;
      keys_tried <= '0;
    end else begin
      state <= state_nxt;
      if (ld_first) begin
        key_reg    <= KEY_FIRST;
        found_key  <= '0;
        keys_tried <= '0;
      end
      if (adv_key)   key_reg    <= key_sum[KEY_WIDTH-1:0];
      if (inc_tried) keys_tried <= keys_tried + 1'b1;
      if (set_found) found_key  <= key_reg;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_first  = 1'b0;
    inc_tried = 1'b0;
    set_found = 1'b0;
    adv_key   = 1'b0;
    case (state)
      S_IDLE, S_FOUND, S_EXHAUSTED, S_FAULT: begin
        if (start) begin
          state_nxt = S_LAUNCH;
          ld_first  = 1'b1;
        end
      end
      S_LAUNCH: state_nxt = abort ? S_IDLE : S_WAIT;
      S_WAIT: begin
        // abort outranks a finish arriving in the same cycle
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (chk_finish) begin
          inc_tried = 1'b1;
          if (chk_valid) begin
            state_nxt = S_FOUND;
            set_found = 1'b1;
          end else if (past_last) begin
            state_nxt = S_EXHAUSTED;
          end else begin
            state_nxt = S_LAUNCH;
            adv_key   = 1'b1;
          end
        end else if (wd_fire) begin
          state_nxt = S_FAULT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign core_key    = key_reg;
  assign core_start  = (state == S_LAUNCH);
  assign busy        = (state == S_LAUNCH) || (state == S_WAIT);
  assign found       = (state == S_FOUND);
  assign exhausted   = (state == S_EXHAUSTED);
  assign timeout_err = (state == S_FAULT);

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: four configurations driven by directed
// scenarios; a monitor checks every core_start against a queue of expected keys.
`timescale 1ns/1ps
module tb_rc4_key_search_ctrl;
  import rc4_crack_pkg::*;

  localparam int N = 4;
  localparam key_t P_FIRST [N] = '{24'h000000, 24'h000001, 24'hFFFFFE, 24'h000000};
  localparam key_t P_LAST  [N] = '{24'h000003, 24'h000006, 24'hFFFFFF, 24'h000003};
  localparam int   P_STEP  [N] = '{1, 2, 1, 1};
  localparam int   P_TO    [N] = '{0, 0, 0, 16};

  logic clk = 1'b0;
  logic rst;
  logic start [N], abort [N], core_start [N], chk_finish [N], chk_valid [N];
  logic busy [N], found [N], exhausted [N], timeout_err [N];
  key_t core_key [N], found_key [N], keys_tried [N];

  logic stub_en [N], valid_en [N];
  key_t match_key [N];
  int   stub_cnt [N];

  typedef struct {
    int   inst;
    key_t key;
  } launch_t;
  launch_t exp_q[$];

  int n_pass = 0;
  int n_total = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    rc4_key_search_ctrl #(
      .KEY_WIDTH     (24),
      .KEY_FIRST     (P_FIRST[g]),
      .KEY_LAST      (P_LAST[g]),
      .KEY_STEP      (P_STEP[g]),
      .TIMEOUT_CYCLES(P_TO[g])
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start[g]),
      .abort      (abort[g]),
      .core_start (core_start[g]),
      .core_key   (core_key[g]),
      .chk_finish (chk_finish[g]),
      .chk_valid  (chk_valid[g]),
      .busy       (busy[g]),
      .found      (found[g]),
      .exhausted  (exhausted[g]),
      .timeout_err(timeout_err[g]),
      .found_key  (found_key[g]),
      .keys_tried (keys_tried[g])
    );
  end

  initial forever #5 clk = ~clk;

  // stub cracking core: finishes a fixed number of cycles after core_start
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) stub_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (core_start[i] && stub_en[i]) stub_cnt[i] <= 5;
        else if (stub_cnt[i] != 0)       stub_cnt[i] <= stub_cnt[i] - 1;
      end
    end
  end

  always @* begin
    for (int i = 0; i < N; i++) begin
      chk_finish[i] = (stub_cnt[i] == 1);
      chk_valid[i]  = (stub_cnt[i] == 1) && valid_en[i] && (core_key[i] == match_key[i]);
    end
  end

  function automatic void check(string name, longint act, longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endfunction

  function automatic void push(int inst, key_t key);
    launch_t e;
    e.inst = inst;
    e.key  = key;
    exp_q.push_back(e);
  endfunction

  initial begin : monitor
    launch_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < N; i++) begin
          if (core_start[i]) begin
            if (exp_q.size() == 0) begin
              n_total++;
              $display("FAIL launch_unexpected: inst %0d key %0h, required no launch", i, core_key[i]);
            end else begin
              e = exp_q.pop_front();
              check("launch_inst", i, e.inst);
              check("launch_key", core_key[i], e.key);
            end
          end
        end
      end
    end
  end

  task automatic do_start(int i);
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
  endtask

  task automatic wait_done(int i, int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (found[i] || exhausted[i] || timeout_err[i]) return;
    end
    n_total++;
    $display("FAIL wait_done: inst %0d no terminal state within %0d cycles, required one", i, budget);
  endtask

  task automatic wait_cond_tried(int i, key_t val, int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (keys_tried[i] == val) return;
    end
    n_total++;
    $display("FAIL wait_tried: inst %0d keys_tried never reached %0h", i, val);
  endtask

  initial begin : stim
    int lat;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0;
      stub_en[i] = 1'b1; valid_en[i] = 1'b0; match_key[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset values
    @(negedge clk);
    check("rst_core_key0", core_key[0], 24'h000000);
    check("rst_core_key2", core_key[2], 24'hFFFFFE);
    check("rst_busy", busy[0], 0);
    check("rst_core_start", core_start[0], 0);
    check("rst_flags", {found[0], exhausted[0], timeout_err[0]}, 0);
    check("rst_keys_tried", keys_tried[0], 0);
    check("rst_found_key", found_key[0], 0);

    // match on key 2 in range 0..3
    valid_en[0] = 1'b1; match_key[0] = 24'd2;
    push(0, 24'd0); push(0, 24'd1); push(0, 24'd2);
    do_start(0);
    wait_done(0, 200);
    check("t1_found", found[0], 1);
    check("t1_found_key", found_key[0], 24'd2);
    check("t1_keys_tried", keys_tried[0], 3);
    check("t1_busy", busy[0], 0);
    check("t1_exhausted", exhausted[0], 0);
    check("t1_queue", exp_q.size(), 0);

    // no match: whole range, restarted from FOUND
    valid_en[0] = 1'b0;
    push(0, 24'd0); push(0, 24'd1); push(0, 24'd2); push(0, 24'd3);
    do_start(0);
    wait_done(0, 200);
    check("t2_exhausted", exhausted[0], 1);
    check("t2_found", found[0], 0);
    check("t2_keys_tried", keys_tried[0], 4);
    check("t2_core_key", core_key[0], 24'd3);
    check("t2_found_key", found_key[0], 0);
    check("t2_queue", exp_q.size(), 0);

    // step 2 over 1..6, start and abort together in IDLE
    push(1, 24'd1); push(1, 24'd3); push(1, 24'd5);
    @(posedge clk); #1 start[1] = 1'b1; abort[1] = 1'b1;
    @(posedge clk); #1 start[1] = 1'b0; abort[1] = 1'b0;
    wait_done(1, 200);
    check("t3_exhausted", exhausted[1], 1);
    check("t3_keys_tried", keys_tried[1], 3);
    check("t3_core_key", core_key[1], 24'd5);
    check("t3_queue", exp_q.size(), 0);

    // top of key space, no wrap
    push(2, 24'hFFFFFE); push(2, 24'hFFFFFF);
    do_start(2);
    wait_done(2, 200);
    check("t4_exhausted", exhausted[2], 1);
    check("t4_keys_tried", keys_tried[2], 2);
    check("t4_core_key", core_key[2], 24'hFFFFFF);
    check("t4_queue", exp_q.size(), 0);

    // watchdog: core never finishes, 16 WAIT cycles allowed
    stub_en[3] = 1'b0;
    push(3, 24'd0);
    do_start(3);
    lat = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      lat++;
      if (timeout_err[3]) break;
    end
    check("t5_latency", lat, 18);
    check("t5_timeout_err", timeout_err[3], 1);
    check("t5_keys_tried", keys_tried[3], 0);
    check("t5_busy", busy[3], 0);
    stub_en[3] = 1'b1; valid_en[3] = 1'b1; match_key[3] = 24'd1;
    push(3, 24'd0); push(3, 24'd1);
    do_start(3);
    wait_done(3, 200);
    check("t5_restart_timeout_err", timeout_err[3], 0);
    check("t5_restart_found", found[3], 1);
    check("t5_restart_found_key", found_key[3], 24'd1);
    check("t5_restart_keys_tried", keys_tried[3], 2);

    // abort in the same cycle as a valid finish
    valid_en[0] = 1'b1; match_key[0] = 24'd0;
    push(0, 24'd0);
    do_start(0);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (chk_finish[0]) break;
    end
    check("t6_finish_seen", chk_finish[0], 1);
    abort[0] = 1'b1;
    @(posedge clk); #1 abort[0] = 1'b0;
    @(negedge clk);
    check("t6_found", found[0], 0);
    check("t6_busy", busy[0], 0);
    check("t6_exhausted", exhausted[0], 0);
    check("t6_keys_tried", keys_tried[0], 0);

    // async reset mid-WAIT of the second key
    valid_en[0] = 1'b0;
    push(0, 24'd0); push(0, 24'd1);
    do_start(0);
    wait_cond_tried(0, 24'd1, 50);
    @(negedge clk);
    check("t7_pre_busy", busy[0], 1);
    #1 rst = 1'b1;
    #1;
    check("t7_busy", busy[0], 0);
    check("t7_core_start", core_start[0], 0);
    check("t7_core_key", core_key[0], 24'd0);
    check("t7_keys_tried", keys_tried[0], 0);
    check("t7_flags", {found[0], exhausted[0], timeout_err[0]}, 0);
    @(posedge clk); #1 rst = 1'b0;

    repeat (10) @(negedge clk);
    check("final_queue", exp_q.size(), 0);
    check("final_idle", busy[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
